uart_tx_frame: RTL
==================

# uart_tx_frame

Parametrised UART transmit framer: accepts one data word per valid/ready handshake and serialises it as start bit, DATA_W data bits (LSB first), optional parity bit and 1 or 2 stop bits, each bit held for CLKS_PER_BIT clocks. It is the next-generation transmit path of the UART: it replaces the fixed 8-bit, fixed-format output select with an internal FSM, baud counter and bit counter. It drives the serial line directly.

## Interface
- DATA_W, 8: data bits per frame, legal 5..9.
- CLKS_PER_BIT, 868: clocks per bit period, legal ≥ 2.
- STOP_BITS, 1: stop bits per frame, legal 1 or 2.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- tx_data  in  DATA_W  word to send; sampled only on accept.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  framer idle and able to accept; reset 1.
- parity_mode  in  2  00 none, 01 even, 10 odd, 11 none; sampled on accept (present only with UART_TX_PARITY_EN).
- tx_serial  out  1  serial line, idle high; reset 1.
- tx_busy  out  1  frame in progress; reset 0.
- tx_done  out  1  one-cycle pulse in last cycle of the final stop bit; reset 0.

## Operation
- States: IDLE=3'b000, START=3'b001, DATA=3'b010, PARITY=3'b011, STOP=3'b100; codes 101..111 map to IDLE on the next cycle with tx_serial=1.
- Line value per state: IDLE 1, START 0, DATA shift_reg[0], PARITY parity bit, STOP 1; registered output.
- Accept: tx_valid && tx_ready in IDLE → latch tx_data into shift register, latch parity_mode, compute parity bit from the latched word (even: XOR of bits; odd: inverted XOR), go to START.
- Baud counter counts 0..CLKS_PER_BIT-1, cleared on accept and on every state change; bit_end = (count == CLKS_PER_BIT-1).
- START → DATA on bit_end. DATA: at each bit_end shift right by one; after DATA_W bits go to PARITY if mode is even/odd, else STOP.
- PARITY → STOP on bit_end. STOP: stop counter counts STOP_BITS bit periods; at the final bit_end assert tx_done and return to IDLE.
- tx_ready = (state == IDLE); tx_busy = !tx_ready. tx_data/parity_mode changes while busy have no effect on the frame in flight.
- Bit counter width $clog2(DATA_W+1); baud counter width $clog2(CLKS_PER_BIT); no wrap beyond terminal values.

## Timing
- Accept at edge N → tx_serial low from cycle N+1 for CLKS_PER_BIT cycles.
- Frame length F = (1 + DATA_W + P + STOP_BITS) × CLKS_PER_BIT cycles, P = 1 with parity else 0.
- tx_done high in cycle N+F; tx_ready high in cycle N+F+1; earliest next accept at N+F+1, so back-to-back start bit follows the last stop bit with no extra idle cycle beyond one clock.
- tx_valid held high continuously: one frame per F+1 cycles, no words dropped or duplicated.
- rst asserted at any point, including mid-frame: next cycle state=IDLE, tx_serial=1, tx_busy=0, tx_done=0, tx_ready=1; in-flight word discarded. rst has priority over accept in the same cycle.

## Configuration
- UART_TX_PARITY_EN defined: parity_mode port present, PARITY state reachable, frame format runtime-selectable.
- Undefined: no parity_mode port, no parity logic; DATA always goes to STOP; P = 0.

## Structure
- Package uart_pkg: state typedef and the five state codes, parity mode constants (PAR_NONE, PAR_EVEN, PAR_ODD), shared with the receive side.
- One sub-module: uart_baud_tick (CLKS_PER_BIT counter with clear input and bit_end output), reused by the receiver.

## Test plan
- DATA_W=8, CLKS_PER_BIT=4, 1 stop, no parity; send 0xA5 → line 0,1,0,1,0,0,1,0,1,1, each 4 cycles; tx_done at cycle 40 after accept.
- Same, even parity, 0xA5 → parity bit 0, 44-cycle frame; odd parity → parity bit 1.
- STOP_BITS=2, send 0x00 → stop level high 8 cycles; tx_ready rises cycle after tx_done.
- tx_valid held high with 0x3C then 0xC3 → two contiguous frames, second start bit exactly one cycle after first tx_done, tx_data change during frame 1 ignored.
- rst pulsed mid-DATA of 0xFF → tx_serial=1 and tx_ready=1 the next cycle, no tx_done; following word 0x55 sent correctly.
- DATA_W=5, send 5'h1F with odd parity → five 1s, parity bit 0, frame 32 cycles at CLKS_PER_BIT=4.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and parity mode constants shared by the UART
// transmit and receive paths.
package uart_pkg;

   // Framer state register encoding; codes 3'b101..3'b111 are unused.
   typedef logic [2:0] uart_state_t;

   localparam uart_state_t ST_IDLE   = 3'b000;
   localparam uart_state_t ST_START  = 3'b001;
   localparam uart_state_t ST_DATA   = 3'b010;
   localparam uart_state_t ST_PARITY = 3'b011;
   localparam uart_state_t ST_STOP   = 3'b100;

   // Runtime parity selection; 2'b11 is treated like PAR_NONE.
   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period counter. Counts 0..CLKS_PER_BIT-1 and flags the
// last clock of each bit period. A clear forces the count back to zero so a
// new bit period starts aligned to the framer's state change.
module uart_baud_tick #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic bit_end
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   assign bit_end = (count_q == LAST);

   // Next count: wrap at the end of a bit period, restart on clear.
   always_comb begin
      count_d = count_q + CW'(1);
      if (clear || bit_end) begin
         count_d = '0;
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmit framer. One word per valid/ready handshake is
// sent as start bit, DATA_W data bits LSB first, optional parity bit and
// STOP_BITS stop bits, each bit lasting CLKS_PER_BIT clocks.
//
// Handshake: a word is taken on a rising edge where tx_valid && tx_ready;
// tx_ready is high only in IDLE, tx_data/parity_mode are ignored otherwise.
//
// Optional feature macro: UART_TX_PARITY_EN adds the parity_mode port and the
// PARITY state. Without it every frame goes straight from DATA to STOP.
module uart_tx_frame #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 868,
   parameter int STOP_BITS    = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
`ifdef UART_TX_PARITY_EN
   input  logic [1:0]        parity_mode,
`endif
   output logic              tx_serial,
   output logic              tx_busy,
   output logic              tx_done
);

   import uart_pkg::*;

   localparam int BW = $clog2(DATA_W + 1);
   localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);
   localparam logic          LAST_STOP = (STOP_BITS == 2);

   uart_state_t       state_q,     state_d;
   logic [DATA_W-1:0] shift_q,     shift_d;
   logic [BW-1:0]     bit_cnt_q,   bit_cnt_d;
   logic              stop_cnt_q,  stop_cnt_d;
   logic              tx_serial_q, tx_serial_d;
   logic              bit_end;
   logic              baud_clear;

`ifdef UART_TX_PARITY_EN
   logic [1:0] par_mode_q, par_mode_d;
   logic       par_bit_q,  par_bit_d;
   logic       par_on;

   assign par_on = (par_mode_q == PAR_EVEN) || (par_mode_q == PAR_ODD);
`endif

   // Every state change (including the accept) starts a fresh bit period.
   assign baud_clear = (state_d != state_q);

   uart_baud_tick #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk     (clk),
      .rst     (rst),
      .clear   (baud_clear),
      .bit_end (bit_end)
   );

   assign tx_ready  = (state_q == ST_IDLE);
   assign tx_busy   = !tx_ready;
   assign tx_serial = tx_serial_q;
   assign tx_done   = (state_q == ST_STOP) && bit_end && (stop_cnt_q == LAST_STOP);

   // Frame sequencing: accept, then walk START/DATA/(PARITY)/STOP on bit ends.
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      stop_cnt_d = stop_cnt_q;
`ifdef UART_TX_PARITY_EN
      par_mode_d = par_mode_q;
      par_bit_d  = par_bit_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (tx_valid) begin
               state_d    = ST_START;
               shift_d    = tx_data;
               bit_cnt_d  = '0;
               stop_cnt_d = 1'b0;
`ifdef UART_TX_PARITY_EN
               par_mode_d = parity_mode;
               // Even: XOR of the word; odd: its inverse.
               par_bit_d  = (^tx_data) ^ (parity_mode == PAR_ODD);
`endif
            end
         end
         ST_START: begin
            if (bit_end) begin
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               shift_d = shift_q >> 1;
               if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                  state_d = par_on ? ST_PARITY : ST_STOP;
`else
                  state_d = ST_STOP;
`endif
               end else begin
                  bit_cnt_d = bit_cnt_q + BW'(1);
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (bit_end) begin
               state_d = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            if (bit_end) begin
               if (stop_cnt_q == LAST_STOP) begin
                  state_d = ST_IDLE;
               end else begin
                  stop_cnt_d = stop_cnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Line level for the coming cycle, registered so tx_serial is glitch-free.
   always_comb begin
      tx_serial_d = 1'b1;
      case (state_d)
         ST_IDLE:   tx_serial_d = 1'b1;
         ST_START:  tx_serial_d = 1'b0;
         ST_DATA:   tx_serial_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         ST_PARITY: tx_serial_d = par_bit_d;
`endif
         ST_STOP:   tx_serial_d = 1'b1;
         default:   tx_serial_d = 1'b1;
      endcase
   end

   // State registers; reset discards any frame in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         stop_cnt_q  <= 1'b0;
         tx_serial_q <= 1'b1;
`ifdef UART_TX_PARITY_EN
         par_mode_q  <= PAR_NONE;
         par_bit_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         stop_cnt_q  <= stop_cnt_d;
         tx_serial_q <= tx_serial_d;
`ifdef UART_TX_PARITY_EN
         par_mode_q  <= par_mode_d;
         par_bit_q   <= par_bit_d;
`endif
      end
   end

endmodule
